// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 key matrix: FSM states, matrix size and
// key-index field layout, common to the scanner, decoder and emulator.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KEY_W   = 4;

  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    HOLD   = 2'd2,
    GAP    = 2'd3
  } kp_state_e;

  function automatic int kp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_col_decode.sv
// Combinational column drive for one pressed key: the key's column answers
// only when its own row is strobed alone and the contact is closed.
module keypad_col_decode
  import keypad_pkg::*;
(
  input  logic [KP_ROWS-1:0] row,
  input  logic [KEY_W-1:0]   key_idx,
  input  logic               contact,
  output logic [KP_COLS-1:0] col
);

  logic row_onehot;
  logic row_hit;

  assign row_onehot = $onehot(row);
  assign row_hit    = (row == (KP_ROWS'(1) << key_idx[KEY_ROW_MSB:KEY_ROW_LSB]));

  assign col = (contact && row_onehot && row_hit)
             ? (KP_COLS'(1) << key_idx[KEY_COL_MSB:KEY_COL_LSB])
             : '0;

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Responding end of a 4x4 key matrix: accepts timed press commands, plays
// them out as bounce / hold / release-gap, and answers row strobes on col.
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_W        = 16,
  parameter int BOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_ROWS-1:0] row,
  output logic [KP_COLS-1:0] col,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [KEY_W-1:0]   key_idx,
  input  logic [HOLD_W-1:0]  hold_cycles,
  input  logic               abort,
  output logic               busy,
  output logic               done
);

  localparam int BNC_W = $clog2(BOUNCE_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = kp_max(HOLD_W, kp_max(BNC_W, GAP_W));

  localparam logic [CNT_W-1:0] BNC_LOAD = CNT_W'(BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  kp_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [KEY_W-1:0]   key_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               contact_q;
  logic               rdy_q;
  logic               busy_q;
  logic               done_q;

  logic               accept;
  logic [HOLD_W-1:0]  hold_ld;

  // A zero hold request still produces one closed cycle.
  assign hold_ld   = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
  assign key_ready = rdy_q & ~abort;
  assign accept    = key_valid & key_ready;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      hold_q    <= '0;
      contact_q <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            key_q     <= key_idx;
            hold_q    <= hold_ld;
            contact_q <= 1'b1;
            busy_q    <= 1'b1;
            rdy_q     <= 1'b0;
            if (BOUNCE_CYCLES > 0) begin
              state_q <= BOUNCE;
              cnt_q   <= BNC_LOAD;
            end else begin
              state_q <= HOLD;
              cnt_q   <= CNT_W'(hold_ld);
            end
          end
        end
        // Bounce chatters closed/open every cycle, starting closed.
        BOUNCE: begin
          if (abort) begin
            state_q   <= GAP;
            cnt_q     <= GAP_LOAD;
            contact_q <= 1'b0;
            done_q    <= (GAP_CYCLES == 1);
          end else if (cnt_q == CNT_ONE) begin
            state_q   <= HOLD;
            cnt_q     <= CNT_W'(hold_q);
            contact_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q - CNT_ONE;
            contact_q <= ~contact_q;
          end
        end
        HOLD: begin
          if (abort || (cnt_q == CNT_ONE)) begin
            state_q   <= GAP;
            cnt_q     <= GAP_LOAD;
            contact_q <= 1'b0;
            done_q    <= (GAP_CYCLES == 1);
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        // done is registered, so it is armed one cycle ahead of the last gap cycle.
        GAP: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end else begin
            cnt_q  <= cnt_q - CNT_ONE;
            done_q <= (cnt_q == CNT_TWO);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  keypad_col_decode u_col_decode (
    .row     (row),
    .key_idx (key_q),
    .contact (contact_q),
    .col     (col)
  );

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed scoreboard bench: one emulator without bounce, one with 4 bounce cycles.
module tb_keypad_matrix_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  key_idx;
  logic [15:0] hold_cycles;
  logic        abort;
  logic        vld0, vld4;
  logic [3:0]  col0, col4;
  logic        rdy0, rdy4, busy0, busy4, done0, done4;

  bit          sel;
  logic [3:0]  col_s;
  logic        rdy_s, busy_s, done_s;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] row;
    logic       abort;
    logic       vld;
    logic [3:0] col;
    logic       done;
    logic       busy;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  keypad_matrix_emulator #(.HOLD_W(16), .BOUNCE_CYCLES(0), .GAP_CYCLES(8)) dut0 (
    .clk(clk), .rst(rst), .row(row), .col(col0),
    .key_valid(vld0), .key_ready(rdy0), .key_idx(key_idx),
    .hold_cycles(hold_cycles), .abort(abort), .busy(busy0), .done(done0)
  );

  keypad_matrix_emulator #(.HOLD_W(16), .BOUNCE_CYCLES(4), .GAP_CYCLES(8)) dut4 (
    .clk(clk), .rst(rst), .row(row), .col(col4),
    .key_valid(vld4), .key_ready(rdy4), .key_idx(key_idx),
    .hold_cycles(hold_cycles), .abort(abort), .busy(busy4), .done(done4)
  );

  assign col_s  = sel ? col4  : col0;
  assign rdy_s  = sel ? rdy4  : rdy0;
  assign busy_s = sel ? busy4 : busy0;
  assign done_s = sel ? done4 : done0;

  function automatic logic [3:0] exp_col(input logic [3:0] r, input logic [3:0] k, input bit closed);
    int rr;
    case (r)
      4'b0001: rr = 0;
      4'b0010: rr = 1;
      4'b0100: rr = 2;
      4'b1000: rr = 3;
      default: rr = -1;
    endcase
    if (closed && (rr == int'(k[3:2]))) return 4'(4'b0001 << k[1:0]);
    return 4'b0000;
  endfunction

  function automatic void push(input logic [3:0] r, input bit ab, input bit v, input bit closed,
                               input bit dn, input bit bz, input bit rd, input logic [3:0] k);
    exp_t e;
    e.row   = r;
    e.abort = ab;
    e.vld   = v;
    e.col   = exp_col(r, k, closed);
    e.done  = dn;
    e.busy  = bz;
    e.rdy   = rd;
    sb.push_back(e);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drain(input string name);
    exp_t e;
    int   n;
    n = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      row   = e.row;
      abort = e.abort;
      if (sel) vld4 = e.vld; else vld0 = e.vld;
      @(negedge clk);
      chk($sformatf("%s.col[%0d]",   name, n), 16'(col_s),  16'(e.col));
      chk($sformatf("%s.done[%0d]",  name, n), 16'(done_s), 16'(e.done));
      chk($sformatf("%s.busy[%0d]",  name, n), 16'(busy_s), 16'(e.busy));
      chk($sformatf("%s.ready[%0d]", name, n), 16'(rdy_s),  16'(e.rdy));
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] k, input logic [15:0] h, input bit keep,
                       input logic [3:0] k2, input logic [15:0] h2);
    chk("issue.ready", 16'(rdy_s), 16'd1);
    key_idx     = k;
    hold_cycles = h;
    if (sel) vld4 = 1'b1; else vld0 = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) begin
      if (sel) vld4 = 1'b0; else vld0 = 1'b0;
    end
    key_idx     = k2;
    hold_cycles = h2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; row = 4'b0000; key_idx = 4'b0000; hold_cycles = 16'd0;
    abort = 1'b0; vld0 = 1'b0; vld4 = 1'b0; sel = 1'b0;

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    row = 4'b0001;
    #1;
    chk("rst.ready0", 16'(rdy0),  16'd0);
    chk("rst.ready4", 16'(rdy4),  16'd0);
    chk("rst.busy0",  16'(busy0), 16'd0);
    chk("rst.done0",  16'(done0), 16'd0);
    chk("rst.col0",   16'(col0),  16'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) push(4'(4'b0001 << i), 0, 0, 0, 0, 0, 1, 4'b0000);
    drain("idle");

    // No bounce, key row 1 col 2, hold 5, rows cycling.
    sel = 1'b0;
    issue(4'b0110, 16'd5, 1'b0, 4'b1111, 16'd77);
    for (int i = 0; i < 14; i++)
      push(4'(4'b0001 << (i % 4)), 0, 0, i < 5, i == 12, i < 13, i == 13, 4'b0110);
    drain("b0_hold5");

    // Bounce 4, key 0, hold 3, row 0 strobed.
    sel = 1'b1;
    issue(4'b0000, 16'd3, 1'b0, 4'b1010, 16'd9);
    for (int i = 0; i < 16; i++)
      push(4'b0001, 0, 0, (i < 4) ? (i % 2 == 0) : (i < 7), i == 14, i < 15, i == 15, 4'b0000);
    drain("b4_bounce");

    // Abort in HOLD, abort in GAP, abort blocking accept in IDLE.
    sel = 1'b0;
    issue(4'b1111, 16'd100, 1'b0, 4'b0000, 16'd1);
    for (int i = 0; i < 13; i++)
      push((i == 0) ? 4'b0011 : 4'b1000,
           (i == 1) || (i == 4) || (i == 5) || (i == 11),
           i == 11, i < 2, i == 9, i < 10, (i == 10) || (i == 12), 4'b1111);
    drain("abort");

    // key_valid held across completion, second command with zero hold.
    issue(4'b0101, 16'd2, 1'b1, 4'b1000, 16'd0);
    for (int i = 0; i < 21; i++)
      push((i < 2) ? 4'b0010 : 4'b0100, 0, i < 11, (i < 2) || (i == 11),
           (i == 9) || (i == 19), !((i == 10) || (i == 20)), (i == 10) || (i == 20),
           (i < 2) ? 4'b0101 : 4'b1000);
    drain("b2b");

    // Asynchronous reset in the middle of HOLD.
    issue(4'b1111, 16'd50, 1'b0, 4'b0000, 16'd0);
    for (int i = 0; i < 2; i++) push(4'b1000, 0, 0, 1, 0, 1, 0, 4'b1111);
    drain("prerst");
    row = 4'b1000;
    #1;
    chk("midrst.col_before", 16'(col0), 16'b1000);
    rst = 1'b1;
    #1;
    chk("midrst.col_async", 16'(col0),  16'd0);
    chk("midrst.busy",      16'(busy0), 16'd0);
    chk("midrst.ready",     16'(rdy0),  16'd0);
    chk("midrst.done",      16'(done0), 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst.hold_done[%0d]", i), 16'(done0), 16'd0);
      chk($sformatf("midrst.hold_col[%0d]", i),  16'(col0),  16'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push(4'b1000, 0, 0, 0, 0, 0, 1, 4'b0000);
    drain("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
